// File: rtl/alu_operand_stage_if.sv
// Control-unit / ALU side signal bundle for alu_operand_stage.
// master: control unit plus external ALU; slave: the operand stage itself.
interface alu_operand_stage_if;
  logic [31:0] bus_in;
  logic        y_in;
  logic        start;
  logic [3:0]  op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [63:0] alu_result;
  logic [31:0] z_hi;
  logic [31:0] z_lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output bus_in, y_in, start, op, alu_result,
    input  alu_a, alu_b, alu_op, z_hi, z_lo, busy, done, div_zero
  );

  modport slave (
    input  bus_in, y_in, start, op, alu_result,
    output alu_a, alu_b, alu_op, z_hi, z_lo, busy, done, div_zero
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Sequential wrapper around the combinational ALU: latches operands for a settle
// window, then captures the 64-bit result into Z and pulses done.
module alu_operand_stage #(
  parameter int unsigned BASIC_WAIT  = 1,
  parameter int unsigned MULDIV_WAIT = 4
) (
  input logic                clock,
  input logic                clear,
  alu_operand_stage_if.slave bus
);
  typedef enum logic {IDLE, SETTLE} state_e;

  localparam logic [3:0] OP_MUL     = 4'd4;
  localparam logic [3:0] OP_DIV     = 4'd5;
  localparam logic [3:0] BASIC_CNT  = 4'(BASIC_WAIT);
  localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_WAIT);

  state_e      state_q, state_d;
  logic [31:0] y_q, y_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] zhi_q, zhi_d;
  logic [31:0] zlo_q, zlo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  always_comb begin
    state_d = state_q;
    y_d     = bus.y_in ? bus.bus_in : y_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Operand A comes from the pre-edge Y, so a same-edge y_in load is not seen.
          a_d     = y_q;
          b_d     = bus.bus_in;
          op_d    = bus.op;
          cnt_d   = (bus.op == OP_MUL || bus.op == OP_DIV) ? MULDIV_CNT : BASIC_CNT;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          zhi_d   = bus.alu_result[63:32];
          zlo_d   = bus.alu_result[31:0];
          dz_d    = (op_q == OP_DIV) && (b_q == '0);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      y_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.alu_op   = op_q;
  assign bus.z_hi     = zhi_q;
  assign bus.z_lo     = zlo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage with a behavioural ALU on the far side.
module tb_alu_operand_stage;
  localparam int BW = 1;
  localparam int MW = 4;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic clock;
  logic clear;
  alu_operand_stage_if bus ();

  alu_operand_stage #(.BASIC_WAIT(BW), .MULDIV_WAIT(MW)) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_seen = 0;
  exp_t sb_q[$];
  logic [31:0] y_m;
  logic        last_dz;

  function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] o);
    logic signed [63:0] sa, sb;
    logic [63:0] aa;
    logic [31:0] r;
    logic [4:0]  sh;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    aa = {a, a};
    sh = b[4:0];
    r  = a & b;
    case (o)
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a - b;
      4'd4:  return 64'(sa * sb);
      4'd5:  begin
        if (b == 32'd0) return '0;
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
      4'd6:  r = a >> sh;
      4'd7:  r = 32'($signed(a) >>> sh);
      4'd8:  r = a << sh;
      4'd9:  r = 32'((aa >> sh));
      4'd10: r = 32'(((aa << sh) >> 32));
      4'd11: r = -a;
      4'd12: r = ~a;
      default: r = a & b;
    endcase
    return {32'd0, r};
  endfunction

  assign bus.alu_result = ref_alu(bus.alu_a, bus.alu_b, bus.alu_op);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  always @(negedge clock) begin
    if (clear && bus.done) begin
      exp_t e;
      done_seen++;
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'(1), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check("z_hi", 64'(bus.z_hi), 64'(e.hi));
        check("z_lo", 64'(bus.z_lo), 64'(e.lo));
        check("div_zero", 64'(bus.div_zero), 64'(e.dz));
      end
    end
  end

  task automatic load_y(input logic [31:0] v);
    bus.y_in   = 1'b1;
    bus.bus_in = v;
    @(posedge clock); #1;
    bus.y_in   = 1'b0;
    y_m        = v;
  endtask

  // Drives start (optionally with a coincident Y load), then walks the settle window.
  task automatic run_op(input logic [3:0] o, input logic [31:0] b, input int w,
                        input bit yload, input bit poke);
    logic [63:0] r;
    exp_t e;
    logic [31:0] a_exp;
    a_exp      = y_m;
    r          = ref_alu(a_exp, b, o);
    e.hi       = r[63:32];
    e.lo       = r[31:0];
    e.dz       = (o == 4'd5) && (b == 32'd0);
    sb_q.push_back(e);
    bus.start  = 1'b1;
    bus.op     = o;
    bus.bus_in = b;
    bus.y_in   = yload;
    @(posedge clock); #1;
    bus.start  = 1'b0;
    bus.y_in   = 1'b0;
    if (yload) y_m = b;
    check("busy_start", 64'(bus.busy), 64'(1));
    check("done_low", 64'(bus.done), 64'(0));
    check("alu_a", 64'(bus.alu_a), 64'(a_exp));
    check("alu_b", 64'(bus.alu_b), 64'(b));
    check("alu_op", 64'(bus.alu_op), 64'(o));
    check("dz_hold", 64'(bus.div_zero), 64'(last_dz));
    for (int i = 1; i < w; i++) begin
      if (poke) begin
        bus.start  = 1'b1;
        bus.op     = 4'd0;
        bus.bus_in = 32'hDEAD_BEEF;
      end
      @(posedge clock); #1;
      check("busy_settle", 64'(bus.busy), 64'(1));
      check("done_settle", 64'(bus.done), 64'(0));
      check("a_held", 64'(bus.alu_a), 64'(a_exp));
      check("op_held", 64'(bus.alu_op), 64'(o));
    end
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("done_pulse", 64'(bus.done), 64'(1));
    check("busy_clear", 64'(bus.busy), 64'(0));
    last_dz = e.dz;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, 64'(bus.alu_a), 64'(0));
    check({tag, "_b"}, 64'(bus.alu_b), 64'(0));
    check({tag, "_op"}, 64'(bus.alu_op), 64'(0));
    check({tag, "_z"}, {bus.z_hi, bus.z_lo}, 64'(0));
    check({tag, "_flags"}, 64'({bus.busy, bus.done, bus.div_zero}), 64'(0));
  endtask

  initial begin
    int   d0;
    exp_t drop;
    clear      = 1'b0;
    bus.bus_in = '0;
    bus.y_in   = 1'b0;
    bus.start  = 1'b0;
    bus.op     = '0;
    y_m        = '0;
    last_dz    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    #2 clear = 1'b1;
    @(posedge clock); #1;

    // add, shortest window
    load_y(32'd5);
    run_op(4'd2, 32'd7, BW, 1'b0, 1'b0);
    @(posedge clock); #1;
    check("done_one_cycle", 64'(bus.done), 64'(0));

    // signed mul
    load_y(32'd6);
    run_op(4'd4, 32'hFFFF_FFFD, MW, 1'b0, 1'b0);
    @(posedge clock); #1;

    // div, then div by zero and its persistence
    load_y(32'd17);
    run_op(4'd5, 32'd5, MW, 1'b0, 1'b0);
    run_op(4'd5, 32'd0, MW, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("dz_sticky", 64'(bus.div_zero), 64'(1));
    run_op(4'd2, 32'd1, BW, 1'b0, 1'b0);
    @(posedge clock); #1;
    check("dz_cleared", 64'(bus.div_zero), 64'(0));

    // coincident Y load and start: operand A is the old Y
    load_y(32'd1);
    run_op(4'd2, 32'd9, BW, 1'b1, 1'b0);
    @(posedge clock); #1;
    run_op(4'd2, 32'd0, BW, 1'b0, 1'b0);
    @(posedge clock); #1;

    // start ignored during SETTLE, then back-to-back accept on the IDLE cycle
    load_y(32'd3);
    d0 = done_seen;
    run_op(4'd4, 32'd5, MW, 1'b0, 1'b1);
    run_op(4'd8, 32'd2, BW, 1'b0, 1'b0);
    run_op(4'd13, 32'h0000_00F0, BW, 1'b0, 1'b0);
    @(posedge clock); #1;
    @(negedge clock); #1;
    check("done_count", 64'(done_seen - d0), 64'(3));

    // asynchronous reset mid-division
    load_y(32'd100);
    drop.hi = '0; drop.lo = '0; drop.dz = 1'b0;
    sb_q.push_back(drop);
    bus.start  = 1'b1;
    bus.op     = 4'd5;
    bus.bus_in = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(posedge clock); #1;
    d0    = done_seen;
    clear = 1'b0;
    #1;
    check_all_zero("abort");
    void'(sb_q.pop_back());
    repeat (MW + 2) @(posedge clock);
    #3;
    check("abort_no_done", 64'(done_seen - d0), 64'(0));
    clear   = 1'b1;
    y_m     = '0;
    last_dz = 1'b0;
    @(posedge clock); #1;
    load_y(32'd20);
    run_op(4'd2, 32'd22, BW, 1'b0, 1'b0);

    @(posedge clock); #1;
    @(negedge clock); #1;
    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Sequential wrapper stage around the combinational ALU of the datapath.
- Upstream side: Y register, plus an operand/opcode latch that drives the ALU inputs stably for a configurable settle window.
- Downstream side: captures the ALU's 64-bit result into Z-high/Z-low registers and signals completion with a one-cycle pulse.
- Gives the control unit a start/busy/done handshake instead of relying on combinational settle timing.

Parameters:
- BASIC_WAIT, 1, settle cycles for ops other than 4 (mul) and 5 (div); legal range 1..15.
- MULDIV_WAIT, 4, settle cycles for ops 4 and 5; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-low reset.
- bus_in  in  32  datapath bus; source for the Y register and for operand B.
- y_in  in  1  load Y register from bus_in.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  4  opcode (0 and, 1 or, 2 add, 3 sub, 4 mul, 5 div, 6 shr, 7 shra, 8 shl, 9 ror, 10 rol, 11 neg, 12 not).
- alu_a  out  32  latched operand A, to ALU input a.
- alu_b  out  32  latched operand B, to ALU input b.
- alu_op  out  4  latched opcode, to ALU op.
- alu_result  in  64  ALU result.
- z_hi  out  32  captured alu_result[63:32] (remainder for div).
- z_lo  out  32  captured alu_result[31:0] (quotient for div).
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  last captured op was div with alu_b==0.

Behaviour:
- Reset (clear=0, asynchronous): state IDLE; Y, alu_a, alu_b, alu_op, z_hi, z_lo, counter = 0; busy, done, div_zero = 0. Reset mid-operation aborts it with no done pulse and no Z update.
- Y register: y_in=1 loads bus_in at any clock edge, in any state.
- States: IDLE and SETTLE.
- IDLE:
  - done<=0 on every edge.
  - If start=1: alu_a<=Y (value before any same-edge y_in load); alu_b<=bus_in; alu_op<=op.
  - Same edge: cnt<=MULDIV_WAIT if op is 4 or 5, else BASIC_WAIT; busy<=1; go to SETTLE.
- SETTLE:
  - alu_a, alu_b, alu_op held constant.
  - cnt>1: cnt<=cnt-1.
  - cnt==1: z_hi<=alu_result[63:32]; z_lo<=alu_result[31:0]; div_zero<=(alu_op==5 && alu_b==0); done<=1; busy<=0; go to IDLE.
- start while in SETTLE: ignored, not queued.
- A start in the IDLE cycle right after completion is accepted; done still falls that edge.
- Latency: start sampled at edge k; Z, div_zero and done valid after edge k+WAIT. Back-to-back throughput is one op per WAIT+1 cycles.
- Z holds until the next capture. div_zero is updated only at capture.
- Opcodes 13–15: accepted, use BASIC_WAIT, and capture whatever the ALU produces (its default is and).
- No arithmetic in this block; all widths pass through unchanged.

Test Plan:
1. y_in with bus=5, then start op=2 with bus=7 → after 1 edge: done=1 for 1 cycle, z_lo=12, z_hi=0, busy=0.
2. Y=6, start op=4, B=0xFFFFFFFD → busy for 4 cycles; then z_hi=0xFFFFFFFF, z_lo=0xFFFFFFEE, done pulse.
3. Y=17, start op=5, B=5 → z_lo=3, z_hi=2, div_zero=0. Repeat with B=0 → div_zero=1; it stays 1 until the next capture, then clears after an add.
4. Y=1 loaded; y_in=1 with bus=9 coincident with start op=2 → operation uses A=1, B=9, z_lo=10; Y reads 9 afterwards.
5. Pulse start during SETTLE of a mul → ignored, exactly one done; then start op=8 on the done cycle's next edge → accepted, with done=0 on that edge.
6. Start a div, assert clear after 2 cycles → all outputs 0 immediately, no done; after release, a new add completes normally.
